// File: rtl/prefetch_unit.sv
// Instruction prefetch stage feeding the decoder.
// It fetches words sequentially on the instruction bus and keeps a tag queue of
// request PCs to label the in-order responses. Responses are buffered in a FIFO
// that is presented to decode with a valid/ready handshake. A redirect flushes
// the FIFO and marks the responses still in flight for discard.
//
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   jump_i, jump_addr_i     redirect strobe and target (bits[1:0] ignored)
//   ireqvalid_o/ready_i     fetch request handshake, address on ireqaddr_o
//   irspvalid_i/err_i/data  in-order fetch responses, no backpressure
//   ids_valid_o/ready_i     FIFO head handshake to decode
//   ids_ins_o/pc_o/ferr_o   head instruction, its PC and bus-error flag
module prefetch_unit #(
  parameter int unsigned         P_XLEN         = 32,
  parameter int unsigned         P_DEPTH        = 4,
  parameter logic [P_XLEN-1:0]   P_RESET_VECTOR = '0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              jump_i,
  input  logic [P_XLEN-1:0] jump_addr_i,
  output logic              ireqvalid_o,
  input  logic              ireqready_i,
  output logic [P_XLEN-1:0] ireqaddr_o,
  input  logic              irspvalid_i,
  input  logic              irsperr_i,
  input  logic [31:0]       irspdata_i,
  output logic              ids_valid_o,
  input  logic              ids_ready_i,
  output logic [31:0]       ids_ins_o,
  output logic [P_XLEN-1:0] ids_pc_o,
  output logic              ids_ferr_o
);

  localparam int unsigned PW = $clog2(P_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [P_XLEN-1:0] RESET_PC = P_RESET_VECTOR & ~P_XLEN'(3);

  logic [P_XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     disc_q, disc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     tag_rd_q, tag_rd_d;
  logic [PW-1:0]     tag_wr_q, tag_wr_d;
  logic              ids_valid_q, ids_valid_d;
  logic [31:0]       ids_ins_q, ids_ins_d;
  logic [P_XLEN-1:0] ids_pc_q, ids_pc_d;
  logic              ids_ferr_q, ids_ferr_d;

  logic [31:0]       fifo_ins_q [P_DEPTH];
  logic [P_XLEN-1:0] fifo_pc_q  [P_DEPTH];
  logic              fifo_err_q [P_DEPTH];
  logic [P_XLEN-1:0] tag_pc_q   [P_DEPTH];

  logic              credit_c;
  logic              req_fire_c;
  logic              rsp_fire_c;
  logic              tag_pop_c;
  logic              push_c;
  logic              pop_c;
  logic [CW-1:0]     cnt_after_pop_c;
  logic [P_XLEN-1:0] tag_head_c;
  logic              unused_jump_lsb;

  assign unused_jump_lsb = ^jump_addr_i[1:0];

  // Credits cover both buffered entries and every in-flight response.
  assign credit_c    = ((SW'(cnt_q) + SW'(out_q)) < SW'(P_DEPTH));
  assign ireqvalid_o = !reset_i && !jump_i && credit_c;
  assign ireqaddr_o  = pc_q;
  assign req_fire_c  = ireqvalid_o && ireqready_i;

  // A response with nothing outstanding is a leftover from before reset.
  assign rsp_fire_c  = irspvalid_i && (out_q != '0);
  // Tags of discarded responses were flushed with the redirect.
  assign tag_pop_c   = rsp_fire_c && (disc_q == '0);
  assign push_c      = tag_pop_c && !jump_i;
  assign pop_c       = ids_valid_q && ids_ready_i && !jump_i;
  assign tag_head_c  = tag_pc_q[tag_rd_q];

  assign ids_valid_o = ids_valid_q;
  assign ids_ins_o   = ids_ins_q;
  assign ids_pc_o    = ids_pc_q;
  assign ids_ferr_o  = ids_ferr_q;

  // Next-state: counters, pointers and the registered view of the FIFO head.
  always_comb begin
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    disc_d      = disc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    tag_rd_d    = tag_rd_q;
    tag_wr_d    = tag_wr_q;
    ids_valid_d = ids_valid_q;
    ids_ins_d   = ids_ins_q;
    ids_pc_d    = ids_pc_q;
    ids_ferr_d  = ids_ferr_q;

    cnt_after_pop_c = cnt_q - CW'(pop_c);

    if (req_fire_c) begin
      pc_d     = pc_q + P_XLEN'(4);
      tag_wr_d = tag_wr_q + PW'(1);
    end
    out_d = out_q + CW'(req_fire_c) - CW'(rsp_fire_c);
    if (rsp_fire_c && (disc_q != '0)) begin
      disc_d = disc_q - CW'(1);
    end
    if (tag_pop_c) begin
      tag_rd_d = tag_rd_q + PW'(1);
    end
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    cnt_d = cnt_q + CW'(push_c) - CW'(pop_c);

    // Head for next cycle: the incoming word if the FIFO is otherwise empty,
    // else the stored entry; the data outputs hold when nothing is left.
    ids_valid_d = (cnt_d != '0);
    if (cnt_d != '0) begin
      if (cnt_after_pop_c == '0) begin
        ids_ins_d  = irspdata_i;
        ids_pc_d   = tag_head_c;
        ids_ferr_d = irsperr_i;
      end else begin
        ids_ins_d  = fifo_ins_q[rd_ptr_d];
        ids_pc_d   = fifo_pc_q[rd_ptr_d];
        ids_ferr_d = fifo_err_q[rd_ptr_d];
      end
    end

    // Redirect overrides everything; in-flight responses become discards.
    if (jump_i) begin
      pc_d        = {jump_addr_i[P_XLEN-1:2], 2'b00};
      cnt_d       = '0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      tag_rd_d    = '0;
      tag_wr_d    = '0;
      out_d       = out_q - CW'(rsp_fire_c);
      disc_d      = out_q - CW'(rsp_fire_c);
      ids_valid_d = 1'b0;
      ids_ins_d   = ids_ins_q;
      ids_pc_d    = ids_pc_q;
      ids_ferr_d  = ids_ferr_q;
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q        <= RESET_PC;
      cnt_q       <= '0;
      out_q       <= '0;
      disc_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      tag_rd_q    <= '0;
      tag_wr_q    <= '0;
      ids_valid_q <= 1'b0;
      ids_ins_q   <= '0;
      ids_pc_q    <= '0;
      ids_ferr_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      disc_q      <= disc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      tag_rd_q    <= tag_rd_d;
      tag_wr_q    <= tag_wr_d;
      ids_valid_q <= ids_valid_d;
      ids_ins_q   <= ids_ins_d;
      ids_pc_q    <= ids_pc_d;
      ids_ferr_q  <= ids_ferr_d;
    end
  end

  // Storage arrays; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      fifo_ins_q[wr_ptr_q] <= irspdata_i;
      fifo_pc_q[wr_ptr_q]  <= tag_head_c;
      fifo_err_q[wr_ptr_q] <= irsperr_i;
    end
    if (req_fire_c) begin
      tag_pc_q[tag_wr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Randomized bench for prefetch_unit against a queue-based reference model.
module tb_prefetch_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        reset_i, jump_i, ireqvalid_o, ireqready_i;
  logic [31:0] jump_addr_i, ireqaddr_o;
  logic        irspvalid_i, irsperr_i;
  logic [31:0] irspdata_i;
  logic        ids_valid_o, ids_ready_i, ids_ferr_o;
  logic [31:0] ids_ins_o, ids_pc_o;

  always #5 clk_i = ~clk_i;

  prefetch_unit #(.P_XLEN(XLEN), .P_DEPTH(DEPTH), .P_RESET_VECTOR(RV)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .ireqvalid_o(ireqvalid_o), .ireqready_i(ireqready_i), .ireqaddr_o(ireqaddr_o),
    .irspvalid_i(irspvalid_i), .irsperr_i(irsperr_i), .irspdata_i(irspdata_i),
    .ids_valid_o(ids_valid_o), .ids_ready_i(ids_ready_i), .ids_ins_o(ids_ins_o),
    .ids_pc_o(ids_pc_o), .ids_ferr_o(ids_ferr_o)
  );

  typedef struct packed { logic [31:0] ins; logic [31:0] pc; logic err; } entry_t;
  typedef struct packed { logic [31:0] addr; int due; } pend_t;

  // Reference model: what decode should see, plus the bus in flight.
  entry_t      m_fifo[$];
  entry_t      m_last;
  int          m_out, m_disc;
  logic [31:0] m_pc;
  pend_t       bus_q[$];

  int          cyc, errors, checks, dut_fires;
  logic        c_jump, c_reset, c_dready, c_qready, c_stray;
  logic [31:0] c_jaddr;
  int          lat_min, lat_max, rsp_pct;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (a == 32'h108) || (a[6:2] == 5'd19);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step();
    logic  rsp_v, ref_valid, fire, popped, drop;
    pend_t p;
    entry_t e;
    ireqready_i = c_qready;
    ids_ready_i = c_dready;
    jump_i      = c_jump;
    jump_addr_i = c_jaddr;
    reset_i     = c_reset;
    rsp_v       = 1'b0;
    p           = '0;
    if (c_stray) begin
      irspvalid_i = 1'b1; irspdata_i = 32'hDEAD_BEEF; irsperr_i = 1'b1;
    end else if (bus_q.size() > 0 && bus_q[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
      p = bus_q.pop_front();
      rsp_v = 1'b1;
      irspvalid_i = 1'b1; irspdata_i = data_of(p.addr); irsperr_i = err_of(p.addr);
    end else begin
      irspvalid_i = 1'b0; irspdata_i = $urandom; irsperr_i = 1'($urandom);
    end
    #1;
    ref_valid = !c_reset && !c_jump && (m_fifo.size() + m_out < DEPTH);
    check("ireqvalid", 32'(ireqvalid_o), 32'(ref_valid));
    if (ref_valid) check("ireqaddr", ireqaddr_o, m_pc);
    check("ids_valid", 32'(ids_valid_o), 32'(m_fifo.size() > 0));
    check("ids_ins", ids_ins_o, m_last.ins);
    check("ids_pc", ids_pc_o, m_last.pc);
    check("ids_ferr", 32'(ids_ferr_o), 32'(m_last.err));
    if (ireqvalid_o && ireqready_i) dut_fires++;
    fire = ref_valid && c_qready;

    if (c_reset) begin
      m_pc = RV; m_fifo.delete(); m_out = 0; m_disc = 0; m_last = '0; bus_q.delete();
    end else begin
      popped = (m_fifo.size() > 0) && c_dready && !c_jump;
      drop = 1'b1;
      if (rsp_v) begin
        m_out--;
        drop = (m_disc > 0);
        if (m_disc > 0) m_disc--;
      end
      if (c_jump) begin
        m_fifo.delete();
        m_disc = m_out;
        m_pc = {c_jaddr[31:2], 2'b00};
      end else begin
        if (popped) void'(m_fifo.pop_front());
        if (rsp_v && !drop) begin
          e.ins = data_of(p.addr); e.pc = p.addr; e.err = err_of(p.addr);
          m_fifo.push_back(e);
        end
        if (fire) begin
          p.addr = m_pc;
          p.due  = cyc + $urandom_range(lat_max, lat_min);
          bus_q.push_back(p);
          m_pc = m_pc + 32'd4;
          m_out++;
        end
      end
      if (m_fifo.size() > 0) m_last = m_fifo[0];
    end
    @(posedge clk_i);
    cyc++;
    #1;
  endtask

  task automatic set_ctl(input logic qr, input logic dr, input int lmin, input int lmax, input int pct);
    c_qready = qr; c_dready = dr; lat_min = lmin; lat_max = lmax; rsp_pct = pct;
    c_jump = 1'b0; c_reset = 1'b0; c_stray = 1'b0; c_jaddr = '0;
  endtask

  task automatic jump_to(input logic [31:0] a);
    c_jump = 1'b1; c_jaddr = a;
    step();
    c_jump = 1'b0;
  endtask

  initial begin
    int first;
    logic found;
    errors = 0; checks = 0; cyc = 0; dut_fires = 0;
    reset_i = 1'b1; jump_i = 1'b0; jump_addr_i = '0; ireqready_i = 1'b0;
    irspvalid_i = 1'b0; irsperr_i = 1'b0; irspdata_i = '0; ids_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    m_pc = RV; m_out = 0; m_disc = 0; m_last = '0;
    set_ctl(1'b1, 1'b1, 1, 1, 100);

    // Streaming from the reset vector with 1-cycle latency.
    first = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ids_valid_o && first < 0) begin
        first = cyc;
        check("first_pc", ids_pc_o, RV);
      end
    end
    check("first_valid_cycle", 32'(first), 32'd2);

    // Decode stalled: fill, then a single pop frees exactly one credit.
    c_dready = 1'b0;
    repeat (8) step();
    check("full_valid", 32'(ids_valid_o), 32'd1);
    dut_fires = 0;
    c_dready = 1'b1;
    step();
    c_dready = 1'b0;
    repeat (4) step();
    check("one_refill", 32'(dut_fires), 32'd1);

    // Redirect with several requests in flight.
    set_ctl(1'b1, 1'b1, 3, 3, 100);
    repeat (3) step();
    jump_to(32'h2003);
    check("jump_reqaddr", ireqaddr_o, 32'h2000);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (ids_valid_o) begin
        found = 1'b1;
        check("jump_first_pc", ids_pc_o, 32'h2000);
      end
    end
    if (!found) check("jump_first_valid_timeout", 32'd0, 32'd1);

    // Redirect coinciding with a response.
    set_ctl(1'b1, 1'b1, 1, 1, 100);
    repeat (6) step();
    jump_to(32'h3000);
    repeat (6) step();

    // Reset mid-flight, a leftover response right after, then PC wrap.
    set_ctl(1'b1, 1'b0, 2, 2, 100);
    repeat (4) step();
    c_reset = 1'b1;
    step();
    c_reset = 1'b0;
    check("rst_valid", 32'(ids_valid_o), 32'd0);
    check("rst_addr", ireqaddr_o, RV);
    c_stray = 1'b1; c_dready = 1'b1;
    step();
    c_stray = 1'b0;
    repeat (6) step();
    set_ctl(1'b1, 1'b1, 1, 1, 100);
    jump_to(32'hFFFF_FFF8);
    repeat (8) step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set_ctl($urandom_range(3) != 0, $urandom_range(3) != 0, 1, 4, 70);
      if ($urandom_range(199) == 0) begin
        c_reset = 1'b1;
        step();
        c_reset = 1'b0; c_stray = 1'b1;
        step();
      end else begin
        c_jump = ($urandom_range(24) == 0);
        c_jaddr = $urandom;
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
